// File: rtl/pdu_pkg.sv
// Shared constants for the debug-unit input conditioner: bit ordering of
// the conditioned input vector and default debounce timing.
package pdu_pkg;

   // Number of independently conditioned raw inputs
   localparam int NUM_IN = 8;

   // Position of each raw input inside the packed conditioning vector
   localparam int IDX_RUN   = 0;
   localparam int IDX_STEP  = 1;
   localparam int IDX_VALID = 2;
   localparam int IDX_IN0   = 3;
   localparam int IN_W      = 5;

   // 10 ms at 100 MHz
   localparam int DB_MAX_DEFAULT = 1000000;
   localparam int CNT_W_DEFAULT  = 20;

endpackage

// File: rtl/pdu_input_cond_if.sv
// Board-side bundle for the input conditioner: raw switch/button levels in,
// debounced levels and edge pulses out. The board/bench side is the master,
// the conditioner is the slave.
interface pdu_input_cond_if;

   logic       run_raw;
   logic       step_raw;
   logic       valid_raw;
   logic [4:0] in_raw;

   logic       run;
   logic       step;
   logic       valid;
   logic [4:0] in;
   logic       step_p;
   logic       valid_pn;

   modport master (
      output run_raw, step_raw, valid_raw, in_raw,
      input  run, step, valid, in, step_p, valid_pn
   );

   modport slave (
      input  run_raw, step_raw, valid_raw, in_raw,
      output run, step, valid, in, step_p, valid_pn
   );

endinterface

// File: rtl/pdu_input_cond_db_bit.sv
// Single-bit conditioner: two-flop synchroniser followed by a debounce
// counter. The stable level only follows the synchronised input after it
// has disagreed for DB_MAX consecutive cycles; any agreement restarts the
// count from zero, so the counter can never pass DB_MAX-1.
module db_bit #(
   parameter int DB_MAX = 1000000,
   parameter int CNT_W  = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_MAX - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // Next-state: synchroniser shift and debounce count/commit decision
   always_comb begin
      s1_d     = raw_i;
      s2_d     = s1_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = s2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers, cleared asynchronously so in-flight counts are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/pdu_input_cond.sv
// Debug-unit front end: conditions run/step/valid and the five data
// switches independently, then derives a step rising-edge pulse and a
// valid any-edge pulse from the debounced levels. All outputs are already
// in the clk domain, so downstream logic uses them directly.
module pdu_input_cond
   import pdu_pkg::*;
#(
   parameter int DB_MAX = DB_MAX_DEFAULT,
   parameter int CNT_W  = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   pdu_input_cond_if.slave  bus
);

   logic [NUM_IN-1:0] raw_vec;
   logic [NUM_IN-1:0] stable_vec;

   logic step_prev_q, step_prev_d;
   logic valid_prev_q, valid_prev_d;

   assign raw_vec = {bus.in_raw, bus.valid_raw, bus.step_raw, bus.run_raw};

   // One independent synchroniser/debouncer per raw input
   for (genvar i = 0; i < NUM_IN; i++) begin : g_db
      db_bit #(
         .DB_MAX (DB_MAX),
         .CNT_W  (CNT_W)
      ) u_db_bit (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (raw_vec[i]),
         .stable_o (stable_vec[i])
      );
   end

   // Previous stable step/valid levels for the edge detectors
   always_comb begin
      step_prev_d  = stable_vec[IDX_STEP];
      valid_prev_d = stable_vec[IDX_VALID];
   end

   // Edge-detector history, cleared with the debouncers so no edge is
   // invented at reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_prev_q  <= 1'b0;
         valid_prev_q <= 1'b0;
      end else begin
         step_prev_q  <= step_prev_d;
         valid_prev_q <= valid_prev_d;
      end
   end

   assign bus.run      = stable_vec[IDX_RUN];
   assign bus.step     = stable_vec[IDX_STEP];
   assign bus.valid    = stable_vec[IDX_VALID];
   assign bus.in       = stable_vec[IDX_IN0 +: IN_W];
   assign bus.step_p   = stable_vec[IDX_STEP] & ~step_prev_q;
   assign bus.valid_pn = stable_vec[IDX_VALID] ^ valid_prev_q;

endmodule
